axi_dma_backend_arbiter: RTL and testbench

//  Shares one legacy 1D DMA backend (burst_req/valid/ready, trans_complete) between NumReq requesters.
//  - Round-robin arbitration with a grant locked until the handshake completes.
//  - Records the requester index of every accepted burst in an in-order completion FIFO.
//  - Routes each backend trans_complete pulse back to the owning requester as req_done_o.

---
 rtl/axi_dma_arb_pkg.sv | 43 ++++
 rtl/axi_dma_backend_arbiter_if.sv | 37 +++
 rtl/axi_dma_arb_cpl_fifo.sv | 70 +++++++
 rtl/axi_dma_backend_arbiter.sv | 136 +++++++++++++
 tb/tb_axi_dma_backend_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_dma_arb_pkg.sv
// ============================================================================
// Module   : axi_dma_arb_pkg
// Brief    : Shared types and round-robin helper for the DMA backend arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_dma_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    // Widest requester vector rr_pick accepts; callers zero-extend into it.
    localparam int unsigned MaxReq     = 64;
    localparam int unsigned MaxReqBits = 6;

    // First set bit of valid at or after ptr, searched circularly over n entries.
    // Scanning downwards lets the closest candidate overwrite farther ones.
    function automatic int unsigned rr_pick(input logic [MaxReq-1:0] valid,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        int unsigned idx;
        int unsigned win;
        win = ptr;
        for (int k = MaxReq - 1; k >= 0; k--) begin
            if (k < int'(n)) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[MaxReqBits-1:0]]) begin
                    win = idx;
                end
            end
        end
        return win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_dma_backend_arbiter_if.sv
// ============================================================================
// Module   : axi_dma_backend_arbiter_if
// Brief    : Requester-side and backend-side signal bundle of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi_dma_backend_arbiter_if #(
    parameter int unsigned NumReq      = 4,
    parameter type         burst_req_t = logic
);
    burst_req_t [NumReq-1:0] req_burst_i;
    logic       [NumReq-1:0] req_valid_i;
    logic       [NumReq-1:0] req_ready_o;
    logic       [NumReq-1:0] req_done_o;
    burst_req_t              burst_req_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    trans_complete_i;
    logic                    backend_idle_i;
    logic                    idle_o;
    logic                    cpl_err_o;

    // Arbiter view.
    modport slave (
        input  req_burst_i, req_valid_i, ready_i, trans_complete_i, backend_idle_i,
        output req_ready_o, req_done_o, burst_req_o, valid_o, idle_o, cpl_err_o
    );

    // Environment view: requesters plus backend.
    modport master (
        output req_burst_i, req_valid_i, ready_i, trans_complete_i, backend_idle_i,
        input  req_ready_o, req_done_o, burst_req_o, valid_o, idle_o, cpl_err_o
    );
endinterface

`default_nettype wire

// File: rtl/axi_dma_arb_cpl_fifo.sv
// ============================================================================
// Module   : axi_dma_arb_cpl_fifo
// Brief    : Index FIFO holding the owner of every accepted, uncompleted burst.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_dma_arb_cpl_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                w_push;
    logic                w_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_dma_backend_arbiter.sv
// ============================================================================
// Module   : axi_dma_backend_arbiter
// Brief    : Round-robin share of one 1D DMA backend with in-order completion routing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_dma_backend_arbiter
    import axi_dma_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter type         burst_req_t    = logic,
    parameter int unsigned IdxWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    axi_dma_backend_arbiter_if.slave  bus_if
);
    arb_state_e          state_q;
    logic [IdxWidth-1:0] rr_ptr_q;
    logic [IdxWidth-1:0] rr_ptr_d;
    logic [IdxWidth-1:0] gnt_q;
    logic [NumReq-1:0]   req_done_q;
    logic                cpl_err_q;

    logic [IdxWidth-1:0] w_winner;
    logic [IdxWidth-1:0] w_sel;
    logic [IdxWidth-1:0] w_head;
    logic [NumReq-1:0]   w_req_ready;
    logic                w_offer;
    logic                w_hs;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    assign w_winner = IdxWidth'(rr_pick(MaxReq'(bus_if.req_valid_i), 32'(rr_ptr_q), NumReq));

    // Outputs are held at their reset-state values while rst_i is asserted.
    always_comb begin
        w_offer     = 1'b0;
        w_sel       = rr_ptr_q;
        w_req_ready = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (!w_fifo_full && (|bus_if.req_valid_i)) begin
                        w_offer = 1'b1;
                        w_sel   = w_winner;
                    end
                end
                OFFER: begin
                    w_offer = 1'b1;
                    w_sel   = gnt_q;
                end
                default: begin
                    w_offer = 1'b0;
                end
            endcase
        end
        if (w_offer) begin
            w_req_ready[w_sel] = bus_if.ready_i;
        end
    end

    assign w_hs     = w_offer & bus_if.ready_i;
    assign w_pop    = bus_if.trans_complete_i & ~w_fifo_empty;
    assign rr_ptr_d = (w_sel == IdxWidth'(NumReq - 1)) ? '0 : w_sel + IdxWidth'(1);

    assign bus_if.valid_o     = w_offer;
    assign bus_if.burst_req_o = bus_if.req_burst_i[w_sel];
    assign bus_if.req_ready_o = w_req_ready;
    assign bus_if.req_done_o  = req_done_q;
    assign bus_if.cpl_err_o   = cpl_err_q;
    assign bus_if.idle_o      = bus_if.backend_idle_i &
                                (rst_i | ((state_q == IDLE) & w_fifo_empty));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            req_done_q <= '0;
            cpl_err_q  <= 1'b0;
        end else begin
            req_done_q <= '0;
            if (w_pop) begin
                req_done_q[w_head] <= 1'b1;
            end
            if (bus_if.trans_complete_i && w_fifo_empty) begin
                cpl_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (w_hs) begin
                        rr_ptr_q <= rr_ptr_d;
                    end else if (w_offer) begin
                        gnt_q   <= w_sel;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (w_hs) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // OFFER is only entered below full and cannot grow, so the push never overflows.
    axi_dma_arb_cpl_fifo #(
        .Width (IdxWidth),
        .Depth (MaxOutstanding)
    ) u_cpl_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (w_hs),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    a_offer_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == OFFER) |-> bus_if.req_valid_i[gnt_q]);

    a_ready_onehot: assert property (@(posedge clk_i) $onehot0(bus_if.req_ready_o));

endmodule

`default_nettype wire

// File: tb/tb_axi_dma_backend_arbiter.sv
// ============================================================================
// Module   : tb_axi_dma_backend_arbiter
// Brief    : Vector-table and scoreboard bench for axi_dma_backend_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_dma_backend_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned MAXO = 2;
    localparam int          NV   = 20;

    typedef logic [15:0] burst_t;

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic       cpl;
        logic       exp_valid;
        logic [3:0] exp_rdy;
        logic [1:0] exp_idx;
    } vec_t;

    typedef struct {
        logic [1:0] idx;
        int         due;
    } done_t;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [3:0] mon_exp;

    logic [1:0] model_fifo[$];
    done_t      exp_done_q[$];
    vec_t       vecs[NV];

    axi_dma_backend_arbiter_if #(.NumReq(NREQ), .burst_req_t(burst_t)) bus_if ();

    axi_dma_backend_arbiter #(
        .NumReq         (NREQ),
        .MaxOutstanding (MAXO),
        .burst_req_t    (burst_t)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic burst_t burst_of(input logic [1:0] i);
        return {12'hB00, 2'b00, i};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference FIFO: pop on completion (old contents), then push the new grant.
    task automatic model_step(input logic cpl, input logic hs, input logic [1:0] idx);
        done_t d;
        if (cpl && model_fifo.size() > 0) begin
            d.idx = model_fifo.pop_front();
            d.due = cyc + 1;
            exp_done_q.push_back(d);
        end
        if (hs) begin
            model_fifo.push_back(idx);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input logic cpl);
        bus_if.req_valid_i      = v;
        bus_if.ready_i          = rdy;
        bus_if.trans_complete_i = cpl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp = '0;
            if (exp_done_q.size() > 0 && exp_done_q[0].due == cyc) begin
                mon_exp[exp_done_q[0].idx] = 1'b1;
                void'(exp_done_q.pop_front());
            end
            check($sformatf("req_done_o@%0d", cyc), 32'(bus_if.req_done_o), 32'(mon_exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // fairness, same-cycle push/pop at occupancy 1
        vecs[0]  = '{4'hF, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0};
        vecs[1]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1};
        vecs[2]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[3]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3};
        vecs[4]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[5]  = '{4'h0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[6]  = '{4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
        // grant lock on requester 2 while requester 0 joins
        vecs[7]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[8]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[9]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[10] = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[11] = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[12] = '{4'b0101, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2};
        vecs[13] = '{4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0};
        // FIFO full backpressure; a same-cycle pop does not unblock
        vecs[14] = '{4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[15] = '{4'hF, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[16] = '{4'hF, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1};
        vecs[17] = '{4'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[18] = '{4'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[19] = '{4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};

        for (int i = 0; i < int'(NREQ); i++) begin
            bus_if.req_burst_i[i] = burst_of(2'(i));
        end
        bus_if.backend_idle_i = 1'b1;
        drive(4'hF, 1'b0, 1'b0);
        rst = 1'b1;

        // Reset held for two edges with every requester valid
        next_cycle();
        @(negedge clk);
        check("rst valid_o", 32'(bus_if.valid_o), 32'd0);
        check("rst req_ready_o", 32'(bus_if.req_ready_o), 32'd0);
        check("rst req_done_o", 32'(bus_if.req_done_o), 32'd0);
        check("rst cpl_err_o", 32'(bus_if.cpl_err_o), 32'd0);
        check("rst idle_o hi", 32'(bus_if.idle_o), 32'd1);
        bus_if.backend_idle_i = 1'b0;
        #1;
        check("rst idle_o lo", 32'(bus_if.idle_o), 32'd0);
        next_cycle();
        rst = 1'b0;
        bus_if.backend_idle_i = 1'b1;
        drive(4'h0, 1'b0, 1'b0);
        mon_en = 1'b1;
        @(negedge clk);
        check("post-rst idle_o", 32'(bus_if.idle_o), 32'd1);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].rdy, vecs[i].cpl);
            model_step(vecs[i].cpl, vecs[i].exp_valid & vecs[i].rdy, vecs[i].exp_idx);
            @(negedge clk);
            check($sformatf("v%0d valid_o", i), 32'(bus_if.valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d req_ready_o", i), 32'(bus_if.req_ready_o), 32'(vecs[i].exp_rdy));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d burst_req_o", i), 32'(bus_if.burst_req_o),
                      32'(burst_of(vecs[i].exp_idx)));
            end
            if (i == 11) begin
                check("lock idle_o", 32'(bus_if.idle_o), 32'd0);
            end
            next_cycle();
        end

        @(negedge clk);
        check("drained idle_o", 32'(bus_if.idle_o), 32'd1);
        check("no cpl_err yet", 32'(bus_if.cpl_err_o), 32'd0);
        next_cycle();

        // Spurious completion with nothing outstanding
        drive(4'h0, 1'b0, 1'b1);
        model_step(1'b1, 1'b0, 2'd0);
        next_cycle();
        drive(4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("cpl_err sticky %0d", k), 32'(bus_if.cpl_err_o), 32'd1);
            next_cycle();
        end

        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("cpl_err cleared", 32'(bus_if.cpl_err_o), 32'd0);
        next_cycle();
        next_cycle();

        check("scoreboard drained", 32'(exp_done_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
